// File: rtl/sel_pkg.sv
// Shared selector types for the button front-end and the 2-to-4 decoder.
package sel_pkg;
  localparam int unsigned NUM_W = 2;

  typedef logic [NUM_W-1:0] num_t;

  localparam num_t NUM_MAX = 2'd3;
endpackage

// File: rtl/sel_debounce_counter_debounce.sv
// One button channel: 2-flop synchroniser, counting debouncer and
// rising-edge pulse of the debounced level.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_stable_q;
  logic [CNT_W-1:0] r_cnt;

  // Any return of s2 to the accepted level restarts the count.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1       <= raw_i;
      r_s2       <= r_s1;
      r_stable_q <= r_stable;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level_o = r_stable;
  assign rise_o  = r_stable & ~r_stable_q;
endmodule

// File: rtl/sel_debounce_counter.sv
// Turns debounced up/down button presses into the 2-bit decoder selector
// with a one-cycle change strobe.
module sel_debounce_counter
  import sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic btn_up_i,
  input  logic btn_dn_i,
  output num_t num,
  output logic chg
);
  logic w_up_level;
  logic w_up_rise;
  logic w_dn_level;
  logic w_dn_rise;
  logic w_up_press;
  logic w_dn_press;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .raw_i   (btn_up_i),
    .level_o (w_up_level),
    .rise_o  (w_up_rise)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .raw_i   (btn_dn_i),
    .level_o (w_dn_level),
    .rise_o  (w_dn_rise)
  );

  assign w_up_press = w_up_rise & w_up_level;
  assign w_dn_press = w_dn_rise & w_dn_level;

  // Simultaneous up and down presses cancel.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      num <= '0;
      chg <= 1'b0;
    end else begin
      case ({w_up_press, w_dn_press})
        2'b10: begin
          num <= (num == NUM_MAX) ? '0 : num + NUM_W'(1);
          chg <= 1'b1;
        end
        2'b01: begin
          num <= (num == '0) ? NUM_MAX : num - NUM_W'(1);
          chg <= 1'b1;
        end
        default: chg <= 1'b0;
      endcase
    end
  end
endmodule
